multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Multicycle control unit driving the 32-bit processing datapath. Consumes OpCode (and
//  Funct) from the instruction parser; sequences FETCH/DECODE/EXEC/MEM/WB; drives every
//  datapath control input (RegDst, Branch, Jump, Jal, MemRead, RegWrite, ...) plus PC/IR
//  write enables. Stalls on instruction/data memory handshakes; halts on illegal opcode.
// PARAMETERS
//  ALUOP_W      4    width of AluOP
//  MEM_TIMEOUT  16   max wait cycles for a memory ready before fault (>=1)
//  CNT_W        32   width of performance counters
// PORTS
//  Clk          in   1        sole clock, rising edge
//  ResetN       in   1        asynchronous, active-low reset
//  OpCode       in   6        instruction[31:26]
//  Funct        in   6        instruction[5:0]
//  ImemReady    in   1        instruction word valid this cycle
//  DmemReady    in   1        data memory access complete this cycle
//  AluZero      in   1        ALU zero flag
//  PcWrite      out  1        PC load enable
//  IrWrite      out  1        instruction register load enable
//  AluOP        out  ALUOP_W  0=ADD 1=SUB 2=AND 3=OR 4=SLT 15=use Funct
//  RegDst, Branch, JumpReg, Jump, Jal, And, MemRead, MemToReg, MemWrite, Immediate,
//  RegWrite     out  1 each   datapath controls (Immediate = ALUSrc)
//  State        out  3        current state encoding
//  Halted       out  1        HALT reached; Fault out 1: HALT cause was memory timeout
//  Retired, StallCycles out CNT_W  perf counters (see CONFIGURATION)
// BEHAVIOUR
//  - States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5; 6,7 illegal -> FETCH next cycle.
//  - Reset: State=FETCH, all outputs 0, wait counter 0, latched opcode 0, counters 0.
//  - Outputs Moore: function of State + opcode/funct latched in DECODE only.
//  - FETCH: IrWrite=ImemReady; ImemReady=1 -> DECODE else stay, wait++.
//  - DECODE: latch OpCode/Funct; legal -> EXEC; else -> HALT (Fault=0).
//    Legal: 0x00 R(Funct 0x08=JR), 0x02 J, 0x03 JAL, 0x04 BEQ, 0x08 ADDI, 0x0A SLTI,
//    0x0C ANDI, 0x0D ORI, 0x23 LW, 0x2B SW.
//  - EXEC: R -> AluOP=15,RegDst=1 ->WB; I-ALU -> Immediate=1, AluOP per op ->WB;
//    LW/SW -> Immediate=1, AluOP=ADD ->MEM; BEQ -> AluOP=SUB, Branch=And=1,
//    PcWrite=1 ->FETCH; J -> Jump=PcWrite=1 ->FETCH; JAL -> Jump=Jal=RegWrite=PcWrite=1
//    ->FETCH; JR -> JumpReg=PcWrite=1 ->FETCH.
//  - MEM: LW MemRead=1, SW MemWrite=1, held until DmemReady. DmemReady: LW->WB;
//    SW->FETCH with PcWrite=1 that cycle.
//  - WB: RegWrite=1, MemToReg=1 for LW, RegDst=1 for R; PcWrite=1 -> FETCH.
//  - Wait counter: clears on every state entry; increments each FETCH/MEM cycle with
//    ready low; reaching MEM_TIMEOUT -> HALT, Fault=1. Ready on the timeout cycle wins.
//  - HALT: all controls 0, Halted=1; exits only via ResetN.
//  - ResetN low mid-instruction: immediate return to FETCH, in-flight MemWrite/RegWrite
//    deassert asynchronously; no partial commit afterwards.
//  - Latency (zero-wait memory): R/I-ALU/LW-less 4 cycles, LW 5, SW 4, branch/jump 3.
// CONFIGURATION
//  PERF_CNT_EN defined: Retired increments on each cycle PcWrite=1 (instruction
//  completion); StallCycles increments on each FETCH/MEM cycle with ready low; both
//  wrap at 2^CNT_W, cleared by reset, frozen in HALT.
//  Not defined: Retired and StallCycles tied to 0, counter logic absent.
// TESTING
//  Reset, ImemReady=1, OpCode=0x00 Funct=0x20 -> states 0,1,2,4,0; RegWrite+RegDst in WB.
//  LW 0x23, DmemReady low 3 cycles -> MEM held 4 cycles MemRead=1; WB MemToReg=1; total 8.
//  OpCode=0x3F -> HALT after DECODE, Halted=1 Fault=0, stays 20 cycles until ResetN.
//  SW with DmemReady never high, MEM_TIMEOUT=16 -> HALT after 16 MEM cycles, Fault=1.
//  JAL 0x03 -> EXEC cycle Jump=Jal=RegWrite=PcWrite=1, back to FETCH in 3 cycles.
//  PERF_CNT_EN: 3 instrs (R, LW 2 stalls, J) -> Retired=3, StallCycles=2; ResetN mid-MEM -> 0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//   Multicycle control unit for the 32-bit datapath. Sequences
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB) for each instruction and drives
//   every datapath control plus the PC/IR load enables. Stalls on the
//   instruction/data memory ready handshakes and halts on an illegal opcode
//   or on a memory that never answers.
//
//   Optional feature macro: PERF_CNT_EN
//     When defined, the Retired and StallCycles performance counters are
//     implemented. When undefined, both outputs are tied to zero.
//
// Ports
//   Clk          in   sole clock, rising edge
//   ResetN       in   asynchronous active-low reset
//   OpCode       in   instruction[31:26]
//   Funct        in   instruction[5:0]
//   ImemReady    in   instruction word valid this cycle
//   DmemReady    in   data memory access complete this cycle
//   AluZero      in   ALU zero flag (branch resolution happens in the datapath)
//   PcWrite      out  PC load enable
//   IrWrite      out  instruction register load enable
//   AluOP        out  0=ADD 1=SUB 2=AND 3=OR 4=SLT 15=use Funct
//   RegDst .. RegWrite  out  datapath controls (Immediate selects ALU imm source)
//   State        out  current state encoding
//   Halted       out  HALT reached
//   Fault        out  HALT was caused by a memory timeout
//   Retired      out  instructions completed (PcWrite cycles)
//   StallCycles  out  FETCH/MEM cycles spent waiting for a ready
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic               Clk,
    input  logic               ResetN,
    input  logic [5:0]         OpCode,
    input  logic [5:0]         Funct,
    input  logic               ImemReady,
    input  logic               DmemReady,
    input  logic               AluZero,
    output logic               PcWrite,
    output logic               IrWrite,
    output logic [ALUOP_W-1:0] AluOP,
    output logic               RegDst,
    output logic               Branch,
    output logic               JumpReg,
    output logic               Jump,
    output logic               Jal,
    output logic               And,
    output logic               MemRead,
    output logic               MemToReg,
    output logic               MemWrite,
    output logic               Immediate,
    output logic               RegWrite,
    output logic [2:0]         State,
    output logic               Halted,
    output logic               Fault,
    output logic [CNT_W-1:0]   Retired,
    output logic [CNT_W-1:0]   StallCycles
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] FN_JR   = 6'h08;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(15);

    localparam int               WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic [2:0]        state_reg, state_next;
    logic [WAIT_W-1:0] wait_reg, wait_next;
    logic [5:0]        op_reg, op_next;
    logic [5:0]        funct_reg, funct_next;
    logic              fault_reg, fault_next;
    logic              op_legal;
    logic              unused_alu_zero;

    // Branch taken/not-taken is resolved by the datapath via Branch & AluZero.
    assign unused_alu_zero = AluZero;

    always_comb begin
        unique case (OpCode)
            OP_R, OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_SLTI,
            OP_ANDI, OP_ORI, OP_LW, OP_SW: op_legal = 1'b1;
            default:                       op_legal = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        wait_next  = wait_reg;
        op_next    = op_reg;
        funct_next = funct_reg;
        fault_next = fault_reg;
        case (state_reg)
            S_FETCH: begin
                // A ready arriving on the timeout cycle still wins.
                if (ImemReady) begin
                    state_next = S_DECODE;
                end else if (wait_reg == WAIT_LAST) begin
                    state_next = S_HALT;
                    fault_next = 1'b1;
                end else begin
                    wait_next = wait_reg + 1'b1;
                end
            end
            S_DECODE: begin
                op_next    = OpCode;
                funct_next = Funct;
                state_next = op_legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                case (op_reg)
                    OP_R:                              state_next = (funct_reg == FN_JR) ? S_FETCH : S_WB;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_next = S_WB;
                    OP_LW, OP_SW:                      state_next = S_MEM;
                    default:                           state_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (DmemReady) begin
                    state_next = (op_reg == OP_LW) ? S_WB : S_FETCH;
                end else if (wait_reg == WAIT_LAST) begin
                    state_next = S_HALT;
                    fault_next = 1'b1;
                end else begin
                    wait_next = wait_reg + 1'b1;
                end
            end
            S_WB:    state_next = S_FETCH;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
        // Wait counter restarts on entry to any new state.
        if (state_next != state_reg) begin
            wait_next = '0;
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_reg <= S_FETCH;
            wait_reg  <= '0;
            op_reg    <= '0;
            funct_reg <= '0;
            fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            op_reg    <= op_next;
            funct_reg <= funct_next;
            fault_reg <= fault_next;
        end
    end

    // Control outputs: decoded from the state and the opcode latched in DECODE.
    // IrWrite (FETCH) and the SW completion PcWrite (MEM) also follow the ready.
    always_comb begin
        PcWrite   = 1'b0;
        IrWrite   = 1'b0;
        AluOP     = ALU_ADD;
        RegDst    = 1'b0;
        Branch    = 1'b0;
        JumpReg   = 1'b0;
        Jump      = 1'b0;
        Jal       = 1'b0;
        And       = 1'b0;
        MemRead   = 1'b0;
        MemToReg  = 1'b0;
        MemWrite  = 1'b0;
        Immediate = 1'b0;
        RegWrite  = 1'b0;
        case (state_reg)
            S_FETCH: IrWrite = ImemReady;
            S_EXEC: begin
                case (op_reg)
                    OP_R: begin
                        if (funct_reg == FN_JR) begin
                            JumpReg = 1'b1;
                            PcWrite = 1'b1;
                        end else begin
                            AluOP  = ALU_FUNCT;
                            RegDst = 1'b1;
                        end
                    end
                    OP_ADDI: begin Immediate = 1'b1; AluOP = ALU_ADD; end
                    OP_SLTI: begin Immediate = 1'b1; AluOP = ALU_SLT; end
                    OP_ANDI: begin Immediate = 1'b1; AluOP = ALU_AND; end
                    OP_ORI:  begin Immediate = 1'b1; AluOP = ALU_OR;  end
                    OP_LW, OP_SW: begin Immediate = 1'b1; AluOP = ALU_ADD; end
                    OP_BEQ: begin
                        AluOP   = ALU_SUB;
                        Branch  = 1'b1;
                        And     = 1'b1;
                        PcWrite = 1'b1;
                    end
                    OP_J: begin
                        Jump    = 1'b1;
                        PcWrite = 1'b1;
                    end
                    OP_JAL: begin
                        Jump     = 1'b1;
                        Jal      = 1'b1;
                        RegWrite = 1'b1;
                        PcWrite  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (op_reg == OP_LW) begin
                    MemRead = 1'b1;
                end else begin
                    MemWrite = 1'b1;
                    PcWrite  = DmemReady;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                MemToReg = (op_reg == OP_LW);
                RegDst   = (op_reg == OP_R);
                PcWrite  = 1'b1;
            end
            default: ;
        endcase
    end

    assign State  = state_reg;
    assign Halted = (state_reg == S_HALT);
    assign Fault  = fault_reg;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] retired_reg;
    logic [CNT_W-1:0] stall_reg;
    logic             stall_cycle;

    // Neither condition can occur in HALT, so the counters freeze there.
    assign stall_cycle = ((state_reg == S_FETCH) && !ImemReady) ||
                         ((state_reg == S_MEM)   && !DmemReady);

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            retired_reg <= '0;
            stall_reg   <= '0;
        end else begin
            if (PcWrite) begin
                retired_reg <= retired_reg + 1'b1;
            end
            if (stall_cycle) begin
                stall_reg <= stall_reg + 1'b1;
            end
        end
    end

    assign Retired     = retired_reg;
    assign StallCycles = stall_reg;
`else
    assign Retired     = '0;
    assign StallCycles = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
//   Directed bench for multicycle_control_fsm: a table of single instructions
//   run with zero-wait memory, followed by hand-written multi-cycle sequences
//   (memory stalls, timeouts, illegal opcode, async reset mid-instruction).
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

    logic        Clk = 1'b0;
    logic        ResetN;
    logic [5:0]  OpCode;
    logic [5:0]  Funct;
    logic        ImemReady;
    logic        DmemReady;
    logic        AluZero;
    logic        PcWrite, IrWrite;
    logic [3:0]  AluOP;
    logic        RegDst, Branch, JumpReg, Jump, Jal, And, MemRead, MemToReg;
    logic        MemWrite, Immediate, RegWrite;
    logic [2:0]  State;
    logic        Halted, Fault;
    logic [31:0] Retired, StallCycles;

    multicycle_control_fsm #(
        .ALUOP_W    (4),
        .MEM_TIMEOUT(16),
        .CNT_W      (32)
    ) dut (
        .Clk        (Clk),
        .ResetN     (ResetN),
        .OpCode     (OpCode),
        .Funct      (Funct),
        .ImemReady  (ImemReady),
        .DmemReady  (DmemReady),
        .AluZero    (AluZero),
        .PcWrite    (PcWrite),
        .IrWrite    (IrWrite),
        .AluOP      (AluOP),
        .RegDst     (RegDst),
        .Branch     (Branch),
        .JumpReg    (JumpReg),
        .Jump       (Jump),
        .Jal        (Jal),
        .And        (And),
        .MemRead    (MemRead),
        .MemToReg   (MemToReg),
        .MemWrite   (MemWrite),
        .Immediate  (Immediate),
        .RegWrite   (RegWrite),
        .State      (State),
        .Halted     (Halted),
        .Fault      (Fault),
        .Retired    (Retired),
        .StallCycles(StallCycles)
    );

    always #5 Clk = ~Clk;

    // Control bit positions inside the packed control word
    localparam logic [12:0] C_PC  = 13'h1000;
    localparam logic [12:0] C_IR  = 13'h0800;
    localparam logic [12:0] C_RD  = 13'h0400;
    localparam logic [12:0] C_BR  = 13'h0200;
    localparam logic [12:0] C_JR  = 13'h0100;
    localparam logic [12:0] C_J   = 13'h0080;
    localparam logic [12:0] C_JAL = 13'h0040;
    localparam logic [12:0] C_AND = 13'h0020;
    localparam logic [12:0] C_MR  = 13'h0010;
    localparam logic [12:0] C_M2R = 13'h0008;
    localparam logic [12:0] C_MW  = 13'h0004;
    localparam logic [12:0] C_IMM = 13'h0002;
    localparam logic [12:0] C_RW  = 13'h0001;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  funct;
        int          len;       // cycles from FETCH until back in FETCH
        logic [3:0]  exec_alu;
        logic [12:0] exec_ctl;
        logic [12:0] fin_ctl;   // controls in the last cycle of the instruction
    } vec_t;

    vec_t vecs[11];

    int total_checks = 0;
    int pass_checks  = 0;

    function automatic logic [12:0] ctl_vec();
        return {PcWrite, IrWrite, RegDst, Branch, JumpReg, Jump, Jal, And,
                MemRead, MemToReg, MemWrite, Immediate, RegWrite};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got === exp) begin
            pass_checks++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        ResetN    = 1'b0;
        ImemReady = 1'b0;
        DmemReady = 1'b0;
        OpCode    = 6'h00;
        Funct     = 6'h00;
        repeat (2) @(posedge Clk);
        #1;
        ResetN = 1'b1;
    endtask

    // Runs one instruction starting in FETCH with ImemReady=1. In MEM the data
    // ready is held low for 'dly' cycles. Stops on return to FETCH or on HALT.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int dly,
                             output int n, output int mem_n,
                             output logic [12:0] first_ctl, output logic [12:0] exec_ctl,
                             output logic [3:0] exec_alu, output logic [12:0] mem_ctl,
                             output logic [12:0] last_ctl);
        OpCode    = op;
        Funct     = fn;
        ImemReady = 1'b1;
        n         = 0;
        mem_n     = 0;
        first_ctl = '0;
        exec_ctl  = '0;
        exec_alu  = '0;
        mem_ctl   = '0;
        last_ctl  = '0;
        for (int c = 0; c < 40; c++) begin
            DmemReady = (State == 3'd3) ? (mem_n >= dly) : 1'b0;
            #1;
            if (c == 0) first_ctl = ctl_vec();
            if (State == 3'd2) begin
                exec_ctl = ctl_vec();
                exec_alu = AluOP;
            end
            if (State == 3'd3) begin
                if (mem_n == 0) mem_ctl = ctl_vec();
                mem_n++;
            end
            last_ctl = ctl_vec();
            n++;
            @(posedge Clk);
            #1;
            if (State == 3'd0 || State == 3'd5) break;
        end
        DmemReady = 1'b0;
    endtask

    int          n, mem_n;
    logic [12:0] first_ctl, exec_ctl, mem_ctl, last_ctl;
    logic [3:0]  exec_alu;
    logic        stayed;
    int          guard;

    initial begin
        vecs[0]  = '{"add",  6'h00, 6'h20, 4, 4'd15, C_RD,                   C_RW | C_RD | C_PC};
        vecs[1]  = '{"jr",   6'h00, 6'h08, 3, 4'd0,  C_JR | C_PC,            C_JR | C_PC};
        vecs[2]  = '{"j",    6'h02, 6'h00, 3, 4'd0,  C_J | C_PC,             C_J | C_PC};
        vecs[3]  = '{"jal",  6'h03, 6'h00, 3, 4'd0,  C_J | C_JAL | C_RW | C_PC, C_J | C_JAL | C_RW | C_PC};
        vecs[4]  = '{"beq",  6'h04, 6'h00, 3, 4'd1,  C_BR | C_AND | C_PC,    C_BR | C_AND | C_PC};
        vecs[5]  = '{"addi", 6'h08, 6'h00, 4, 4'd0,  C_IMM,                  C_RW | C_PC};
        vecs[6]  = '{"slti", 6'h0A, 6'h00, 4, 4'd4,  C_IMM,                  C_RW | C_PC};
        vecs[7]  = '{"andi", 6'h0C, 6'h00, 4, 4'd2,  C_IMM,                  C_RW | C_PC};
        vecs[8]  = '{"ori",  6'h0D, 6'h00, 4, 4'd3,  C_IMM,                  C_RW | C_PC};
        vecs[9]  = '{"lw",   6'h23, 6'h00, 5, 4'd0,  C_IMM,                  C_RW | C_M2R | C_PC};
        vecs[10] = '{"sw",   6'h2B, 6'h00, 4, 4'd0,  C_IMM,                  C_MW | C_PC};

        AluZero = 1'b0;
        do_reset();
        ResetN = 1'b0;
        #1;
        check("reset_state",   32'(State), 32'd0);
        check("reset_ctl",     32'(ctl_vec()), 32'd0);
        check("reset_aluop",   32'(AluOP), 32'd0);
        check("reset_halted",  32'({Halted, Fault}), 32'd0);
        check("reset_retired", Retired, 32'd0);
        check("reset_stalls",  StallCycles, 32'd0);
        @(posedge Clk);
        #1;
        ResetN = 1'b1;

        // Zero-wait table
        for (int i = 0; i < 11; i++) begin
            run_instr(vecs[i].op, vecs[i].funct, 0, n, mem_n, first_ctl, exec_ctl,
                      exec_alu, mem_ctl, last_ctl);
            $display("instr %s op=0x%02h cycles=%0d exec_ctl=0x%04h alu=%0d fin_ctl=0x%04h",
                     vecs[i].name, vecs[i].op, n, exec_ctl, exec_alu, last_ctl);
            check({vecs[i].name, "_len"},      32'(n),         32'(vecs[i].len));
            check({vecs[i].name, "_fetch"},    32'(first_ctl), 32'(C_IR));
            check({vecs[i].name, "_exec_ctl"}, 32'(exec_ctl),  32'(vecs[i].exec_ctl));
            check({vecs[i].name, "_exec_alu"}, 32'(exec_alu),  32'(vecs[i].exec_alu));
            check({vecs[i].name, "_fin_ctl"},  32'(last_ctl),  32'(vecs[i].fin_ctl));
        end

        // LW with data ready low for 3 MEM cycles
        run_instr(6'h23, 6'h00, 3, n, mem_n, first_ctl, exec_ctl, exec_alu, mem_ctl, last_ctl);
        $display("lw_stall cycles=%0d mem_cycles=%0d mem_ctl=0x%04h", n, mem_n, mem_ctl);
        check("lw_stall_len",   32'(n),        32'd8);
        check("lw_stall_mem",   32'(mem_n),    32'd4);
        check("lw_stall_mrd",   32'(mem_ctl),  32'(C_MR));
        check("lw_stall_wb",    32'(last_ctl), 32'(C_RW | C_M2R | C_PC));

        // SW: ready arrives on the 16th MEM cycle, which is the timeout cycle
        run_instr(6'h2B, 6'h00, 15, n, mem_n, first_ctl, exec_ctl, exec_alu, mem_ctl, last_ctl);
        $display("sw_ready_at_limit cycles=%0d mem_cycles=%0d state=%0d", n, mem_n, State);
        check("sw_edge_mem",   32'(mem_n),    32'd16);
        check("sw_edge_state", 32'(State),    32'd0);
        check("sw_edge_fin",   32'(last_ctl), 32'(C_MW | C_PC));
        check("sw_edge_fault", 32'(Fault),    32'd0);

        // SW with data ready never high -> timeout HALT
        run_instr(6'h2B, 6'h00, 1000, n, mem_n, first_ctl, exec_ctl, exec_alu, mem_ctl, last_ctl);
        $display("sw_timeout mem_cycles=%0d state=%0d halted=%0b fault=%0b", mem_n, State, Halted, Fault);
        check("sw_to_mem",    32'(mem_n), 32'd16);
        check("sw_to_state",  32'(State), 32'd5);
        check("sw_to_flags",  32'({Halted, Fault}), 32'b11);
        check("sw_to_ctl",    32'(ctl_vec()), 32'd0);

        // Illegal opcode -> HALT after DECODE, held for 20 cycles
        do_reset();
        run_instr(6'h3F, 6'h00, 0, n, mem_n, first_ctl, exec_ctl, exec_alu, mem_ctl, last_ctl);
        stayed = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge Clk);
            #1;
            if (State != 3'd5 || !Halted || ctl_vec() != 13'd0) stayed = 1'b0;
        end
        $display("illegal cycles=%0d state=%0d halted=%0b fault=%0b", n, State, Halted, Fault);
        check("illegal_len",    32'(n), 32'd2);
        check("illegal_flags",  32'({Halted, Fault}), 32'b10);
        check("illegal_stayed", 32'(stayed), 32'd1);

        // Instruction memory never ready -> FETCH timeout
        do_reset();
        ImemReady = 1'b0;
        repeat (15) @(posedge Clk);
        #1;
        $display("fetch_stall state=%0d irwrite=%0b", State, IrWrite);
        check("fetch_wait_state", 32'(State), 32'd0);
        check("fetch_wait_ir",    32'(IrWrite), 32'd0);
        @(posedge Clk);
        #1;
        $display("fetch_timeout state=%0d fault=%0b", State, Fault);
        check("fetch_to_flags", 32'({State, Halted, Fault}), 32'({3'd5, 2'b11}));

        // Performance counters: R, LW with 2 stalls, J
        do_reset();
        run_instr(6'h00, 6'h20, 0, n, mem_n, first_ctl, exec_ctl, exec_alu, mem_ctl, last_ctl);
        run_instr(6'h23, 6'h00, 2, n, mem_n, first_ctl, exec_ctl, exec_alu, mem_ctl, last_ctl);
        run_instr(6'h02, 6'h00, 0, n, mem_n, first_ctl, exec_ctl, exec_alu, mem_ctl, last_ctl);
        $display("perf retired=%0d stalls=%0d", Retired, StallCycles);
`ifdef PERF_CNT_EN
        check("perf_retired", Retired,     32'd3);
        check("perf_stalls",  StallCycles, 32'd2);
`else
        check("perf_retired_off", Retired,     32'd0);
        check("perf_stalls_off",  StallCycles, 32'd0);
`endif

        // Asynchronous reset in the middle of a SW MEM wait
        OpCode    = 6'h2B;
        ImemReady = 1'b1;
        DmemReady = 1'b0;
        guard     = 0;
        while (State != 3'd3 && guard < 10) begin
            @(posedge Clk);
            #1;
            guard++;
        end
        @(posedge Clk);
        #1;
        check("midmem_memwrite", 32'({State, MemWrite}), 32'({3'd3, 1'b1}));
        #2;
        ResetN = 1'b0;
        #1;
        $display("async_reset state=%0d memwrite=%0b retired=%0d stalls=%0d",
                 State, MemWrite, Retired, StallCycles);
        check("areset_state",    32'(State), 32'd0);
        check("areset_memwrite", 32'({MemWrite, RegWrite, PcWrite}), 32'd0);
        check("areset_counters", Retired | StallCycles, 32'd0);
        ResetN = 1'b1;

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
